pipe_ctrl: RTL

Pipeline control unit for the core. It produces the per-stage `hold_flag` inputs of the IF/ID and ID/EX pipeline registers, holds the PC, and issues PC redirects. Three sources drive it: taken branches/jumps resolved in EX, multi-cycle EX operations (divider), and external bus holds. When a pipeline register's `hold_flag` is 1, it loads its NOP `set_data` on the next edge. `pipe_ctrl` decides when that happens.

---
 rtl/pipe_ctrl_pkg.sv | 7 +
 rtl/pipe_ctrl_sat_counter.sv | 14 +
 rtl/pipe_ctrl.sv | 53 +++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared core constants and types for pipeline control
package pipe_ctrl_pkg;
   typedef enum logic {IDLE = 1'b0, MC_WAIT = 1'b1} state_t;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);
   // count enabled cycles, holding once every bit is set
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (en && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage hold, PC hold and redirect control for jumps, multi-cycle ops and bus holds
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             jump_en_i,
   input  logic [31:0]      jump_addr_i,
   input  logic             mc_start_i,
   input  logic [31:0]      mc_pc_i,
   input  logic             mc_done_i,
   input  logic             bus_hold_i,
   output logic             hold_pc_o,
   output logic             hold_ifid_o,
   output logic             hold_idex_o,
   output logic             jump_en_o,
   output logic [31:0]      jump_addr_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] stall_cnt_o
);
   state_t      state, state_nxt;
   logic [31:0] saved_pc;
   logic        idle, mc_take;
   assign idle    = state == IDLE;
   assign mc_take = idle && mc_start_i && !jump_en_i;
   assign busy_o  = state == MC_WAIT;
   // output decode: a jump always wins in IDLE, MC_WAIT freezes everything until done
   always_comb begin
      state_nxt   = idle ? (mc_take ? MC_WAIT : IDLE) : (mc_done_i ? IDLE : MC_WAIT);
      jump_en_o   = idle ? jump_en_i : mc_done_i;
      jump_addr_o = !jump_en_o ? 32'h0 : idle ? jump_addr_i : saved_pc + 32'd4;
      hold_pc_o   = idle ? !jump_en_i && (mc_start_i || bus_hold_i) : !mc_done_i;
      hold_ifid_o = idle ? jump_en_i || mc_start_i || bus_hold_i : 1'b1;
      hold_idex_o = idle ? jump_en_i || mc_start_i : 1'b1;
   end
   // state register and return address of the pending multi-cycle op
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= IDLE;
         saved_pc <= RESET_PC;
      end else begin
         state <= state_nxt;
         if (mc_take) saved_pc <= mc_pc_i;
      end
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (hold_pc_o),
      .cnt (stall_cnt_o)
   );
endmodule
